io_port_decode: RTL and testbench
=================================

Name: io_port_decode

Overview:
- Shared I/O address decoder for memory-mapped I/O ports. It serves both the read and the write side of the pipeline.
- Check path: decides whether an early-stage address targets an I/O port. It also selects that port's Empty/Full bit, masked so that non-I/O accesses always look ready.
- Active path: turns a late-stage I/O write/read address plus an enable into a registered one-hot port strobe.

Parameters:
- ADDR_WIDTH, 10: width of both address inputs.
- PORT_COUNT, 4: number of I/O ports; 1 to 2**PORT_ADDR_WIDTH.
- PORT_BASE_ADDR, 0: first port address; must be aligned to 2**PORT_ADDR_WIDTH.
- PORT_ADDR_WIDTH, 2: low address bits that index a port within the I/O window.
- READY_STATE, 0: Empty/Full bit value meaning "port can be accessed now".

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- check_addr  in  ADDR_WIDTH  address under test (check path).
- port_EF  in  PORT_COUNT  per-port Empty/Full bits; bit i belongs to port i.
- addr_is_IO  out  1  combinational: check_addr hits a port.
- addr_is_IO_reg  out  1  addr_is_IO registered one cycle.
- port_EF_masked  out  1  registered masked Empty/Full of the addressed port.
- active_enable  in  1  qualifies active_addr (e.g. is_IO AND wren).
- active_addr  in  ADDR_WIDTH  address for strobe generation.
- active  out  PORT_COUNT  registered one-hot port strobe.

Behaviour:
- Window match:
  - upper = addr[ADDR_WIDTH-1:PORT_ADDR_WIDTH] equals PORT_BASE_ADDR[ADDR_WIDTH-1:PORT_ADDR_WIDTH].
  - idx = addr[PORT_ADDR_WIDTH-1:0].
  - hit = window match AND idx < PORT_COUNT (see Optional Feature).
- addr_is_IO = hit(check_addr). Purely combinational, no latency.
- At each rising edge, when reset=0:
  - addr_is_IO_reg <= hit(check_addr).
  - port_EF_masked <= hit ? port_EF[idx] : READY_STATE.
- Masking rule: a non-I/O address never stalls, i.e. it always reads READY_STATE.
- Active path, at each rising edge:
  - active <= (active_enable AND hit(active_addr)) ? (1 << idx) : 0.
  - At most one bit of active is set, for exactly one cycle per qualifying cycle.
  - Back-to-back enables to the same port keep that bit high continuously.
- Both paths are independent. They may address the same or different ports in the same cycle with no interaction.
- Latency: check registered outputs 1 cycle; active 1 cycle.
- Reset (synchronous, overrides the clocked update):
  - addr_is_IO_reg = 0.
  - port_EF_masked = READY_STATE.
  - active = 0.
- addr_is_IO is unaffected by reset; it follows check_addr.
- Reset asserted mid-operation clears any pending strobe on the next edge. The first post-reset edge decodes normally.
- Initial (power-up) values equal the reset values.
- No internal state beyond the output registers. port_EF is sampled, never stored across cycles.

Optional Feature:
- Macro IO_PORT_RANGE_CHECK_EN.
- Defined: hit requires idx < PORT_COUNT, as above. Unpopulated window slots are non-I/O: masked read = READY_STATE, no strobe.
- Undefined: hit = window match only. For idx >= PORT_COUNT:
  - addr_is_IO = 1.
  - port_EF_masked = ~READY_STATE (never ready; the access stalls).
  - active = 0.
- For PORT_COUNT = 2**PORT_ADDR_WIDTH both builds are identical.

Test Plan:
Setup: ADDR_WIDTH=10, PORT_COUNT=3, PORT_BASE_ADDR=0x3F8, PORT_ADDR_WIDTH=3, READY_STATE=0.
- Reset: assert reset 2 cycles with active_enable=1, active_addr=0x3F8 -> addr_is_IO_reg=0, port_EF_masked=0, active=3'b000. After release, next edge gives active=3'b001.
- Check hit: check_addr=0x3F9, port_EF=3'b010 -> addr_is_IO=1 immediately. Next edge: addr_is_IO_reg=1, port_EF_masked=1. Change port_EF to 3'b000 -> masked=0 next edge.
- Check miss: check_addr=0x100, port_EF=3'b111 -> addr_is_IO=0; after edge addr_is_IO_reg=0, port_EF_masked=0 (READY_STATE).
- Active: active_enable=1 with addresses 0x3FA, 0x3F8, 0x3FA on consecutive cycles -> active = 3'b100, 3'b001, 3'b100, each one cycle late. active_enable=0 with 0x3FA -> 3'b000.
- Unpopulated slot 0x3FD, port_EF=3'b000:
  - With IO_PORT_RANGE_CHECK_EN: addr_is_IO=0, masked=0, active=0.
  - Without: addr_is_IO=1, masked=1, active=0.
- Simultaneous paths: check_addr=0x3F8 and active_addr=0x3F9 (enable=1), port_EF=3'b001, same cycle -> after edge port_EF_masked=1, addr_is_IO_reg=1, active=3'b010.

Source files
------------

// File: rtl/io_port_decode_if.sv
//------------------------------------------------------------------------------
// Module   : io_port_decode_if
// Brief    : Bundles the check-path and active-path signals of io_port_decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface io_port_decode_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int PORT_COUNT = 4
) ();

  logic [ADDR_WIDTH-1:0] check_addr;
  logic [PORT_COUNT-1:0] port_EF;
  logic                  addr_is_IO;
  logic                  addr_is_IO_reg;
  logic                  port_EF_masked;
  logic                  active_enable;
  logic [ADDR_WIDTH-1:0] active_addr;
  logic [PORT_COUNT-1:0] active;

  modport master (
    output check_addr,
    output port_EF,
    output active_enable,
    output active_addr,
    input  addr_is_IO,
    input  addr_is_IO_reg,
    input  port_EF_masked,
    input  active
  );

  modport slave (
    input  check_addr,
    input  port_EF,
    input  active_enable,
    input  active_addr,
    output addr_is_IO,
    output addr_is_IO_reg,
    output port_EF_masked,
    output active
  );

endinterface

`default_nettype wire

// File: rtl/io_port_decode.sv
//------------------------------------------------------------------------------
// Module   : io_port_decode
// Brief    : Memory-mapped I/O port decoder: combinational/registered port hit
//            with masked Empty/Full, plus a registered one-hot write/read strobe.
//            Optional macro IO_PORT_RANGE_CHECK_EN treats unpopulated window
//            slots as non-I/O instead of never-ready ports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_port_decode #(
  parameter int ADDR_WIDTH      = 10,
  parameter int PORT_COUNT      = 4,
  parameter int PORT_BASE_ADDR  = 0,
  parameter int PORT_ADDR_WIDTH = 2,
  parameter bit READY_STATE     = 1'b0
) (
  input  wire logic         clock,
  input  wire logic         reset,
  io_port_decode_if.slave   bus
);

  localparam int                    C_SLOTS      = 2 ** PORT_ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_BASE       = PORT_BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [31:0]           C_PORT_COUNT = PORT_COUNT;

  function automatic logic decode_hit(input logic [ADDR_WIDTH-1:0] addr);
    logic        window;
    logic [31:0] idx_ext;
    window  = (addr[ADDR_WIDTH-1:PORT_ADDR_WIDTH] == C_BASE[ADDR_WIDTH-1:PORT_ADDR_WIDTH]);
    idx_ext = 32'(addr[PORT_ADDR_WIDTH-1:0]);
`ifdef IO_PORT_RANGE_CHECK_EN
    return window && (idx_ext < C_PORT_COUNT);
`else
    return window && (idx_ext == idx_ext);
`endif
  endfunction

  // Unpopulated slots read as never-ready so a stray access stalls rather than proceeds.
  logic [C_SLOTS-1:0] ef_ext;

  for (genvar gi = 0; gi < C_SLOTS; gi++) begin : g_ef_slot
    if (gi < PORT_COUNT) begin : g_populated
      assign ef_ext[gi] = bus.port_EF[gi];
    end else begin : g_unpopulated
      assign ef_ext[gi] = ~READY_STATE;
    end
  end

  logic                       check_hit;
  logic [PORT_ADDR_WIDTH-1:0] check_idx;
  logic                       active_hit;
  logic [PORT_ADDR_WIDTH-1:0] active_idx;

  logic                  addr_is_io_reg_d;
  logic                  addr_is_io_reg_q;
  logic                  port_ef_masked_d;
  logic                  port_ef_masked_q;
  logic [PORT_COUNT-1:0] active_d;
  logic [PORT_COUNT-1:0] active_q;

  always_comb begin
    check_hit        = decode_hit(bus.check_addr);
    check_idx        = bus.check_addr[PORT_ADDR_WIDTH-1:0];
    active_hit       = bus.active_enable && decode_hit(bus.active_addr);
    active_idx       = bus.active_addr[PORT_ADDR_WIDTH-1:0];

    addr_is_io_reg_d = check_hit;
    port_ef_masked_d = check_hit ? ef_ext[check_idx] : READY_STATE;

    active_d = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      active_d[i] = active_hit && (active_idx == PORT_ADDR_WIDTH'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_is_io_reg_q <= 1'b0;
      port_ef_masked_q <= READY_STATE;
      active_q         <= '0;
    end else begin
      addr_is_io_reg_q <= addr_is_io_reg_d;
      port_ef_masked_q <= port_ef_masked_d;
      active_q         <= active_d;
    end
  end

  assign bus.addr_is_IO     = check_hit;
  assign bus.addr_is_IO_reg = addr_is_io_reg_q;
  assign bus.port_EF_masked = port_ef_masked_q;
  assign bus.active         = active_q;

endmodule

`default_nettype wire

// File: tb/tb_io_port_decode.sv
//------------------------------------------------------------------------------
// Module   : tb_io_port_decode
// Brief    : Directed vector bench for io_port_decode (3 ports at 0x3F8, 8-slot window).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_port_decode;

  localparam int AW = 10;
  localparam int PC = 3;

`ifdef IO_PORT_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk;
  logic rst;

  io_port_decode_if #(.ADDR_WIDTH(AW), .PORT_COUNT(PC)) bus ();

  io_port_decode #(
    .ADDR_WIDTH     (AW),
    .PORT_COUNT     (PC),
    .PORT_BASE_ADDR (32'h3F8),
    .PORT_ADDR_WIDTH(3),
    .READY_STATE    (1'b0)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [AW-1:0] check_addr;
    logic [PC-1:0] port_ef;
    logic          en;
    logic [AW-1:0] active_addr;
    logic          exp_io;
    logic          exp_io_reg;
    logic          exp_masked;
    logic [PC-1:0] exp_active;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [AW-1:0] ca, input logic [PC-1:0] ef,
                       input logic en, input logic [AW-1:0] aa);
    rst                = r;
    bus.check_addr     = ca;
    bus.port_EF        = ef;
    bus.active_enable  = en;
    bus.active_addr    = aa;
  endtask

  vec_t vecs [16];

  initial begin
    // rst  check   ef      en  active  io      io_reg  masked  active
    vecs[0]  = '{1'b1, 10'h3F9, 3'b010, 1'b1, 10'h3F8, 1'b1,  1'b0,  1'b0,  3'b000};
    vecs[1]  = '{1'b1, 10'h3F9, 3'b010, 1'b1, 10'h3F8, 1'b1,  1'b0,  1'b0,  3'b000};
    vecs[2]  = '{1'b0, 10'h100, 3'b111, 1'b1, 10'h3F8, 1'b0,  1'b0,  1'b0,  3'b001};
    vecs[3]  = '{1'b0, 10'h3F9, 3'b010, 1'b0, 10'h3F8, 1'b1,  1'b1,  1'b1,  3'b000};
    vecs[4]  = '{1'b0, 10'h3F9, 3'b000, 1'b0, 10'h3F8, 1'b1,  1'b1,  1'b0,  3'b000};
    vecs[5]  = '{1'b0, 10'h100, 3'b111, 1'b1, 10'h3FA, 1'b0,  1'b0,  1'b0,  3'b100};
    vecs[6]  = '{1'b0, 10'h100, 3'b111, 1'b1, 10'h3F8, 1'b0,  1'b0,  1'b0,  3'b001};
    vecs[7]  = '{1'b0, 10'h100, 3'b111, 1'b1, 10'h3FA, 1'b0,  1'b0,  1'b0,  3'b100};
    vecs[8]  = '{1'b0, 10'h100, 3'b111, 1'b0, 10'h3FA, 1'b0,  1'b0,  1'b0,  3'b000};
    vecs[9]  = '{1'b0, 10'h3FD, 3'b000, 1'b1, 10'h3FD, ~RC,   ~RC,   ~RC,   3'b000};
    vecs[10] = '{1'b0, 10'h3F8, 3'b001, 1'b1, 10'h3F9, 1'b1,  1'b1,  1'b1,  3'b010};
    vecs[11] = '{1'b0, 10'h3FA, 3'b100, 1'b1, 10'h3F9, 1'b1,  1'b1,  1'b1,  3'b010};
    vecs[12] = '{1'b0, 10'h3FA, 3'b011, 1'b1, 10'h3F9, 1'b1,  1'b1,  1'b0,  3'b010};
    vecs[13] = '{1'b0, 10'h3F7, 3'b111, 1'b1, 10'h3F7, 1'b0,  1'b0,  1'b0,  3'b000};
    vecs[14] = '{1'b0, 10'h3FF, 3'b000, 1'b1, 10'h3FF, ~RC,   ~RC,   ~RC,   3'b000};
    vecs[15] = '{1'b0, 10'h3F8, 3'b110, 1'b1, 10'h000, 1'b1,  1'b1,  1'b0,  3'b000};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].check_addr, vecs[i].port_ef, vecs[i].en, vecs[i].active_addr);
      #1;
      chk($sformatf("v%0d addr_is_IO", i), 32'(bus.addr_is_IO), 32'(vecs[i].exp_io));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d addr_is_IO_reg", i), 32'(bus.addr_is_IO_reg), 32'(vecs[i].exp_io_reg));
      chk($sformatf("v%0d port_EF_masked", i), 32'(bus.port_EF_masked), 32'(vecs[i].exp_masked));
      chk($sformatf("v%0d active", i), 32'(bus.active), 32'(vecs[i].exp_active));
    end

    // Back-to-back strobe holds through the cycle, then a mid-operation reset clears it.
    drive(1'b0, 10'h3F9, 3'b111, 1'b1, 10'h3F9);
    @(posedge clk);
    #1;
    chk("seq first strobe", 32'(bus.active), 32'b010);
    @(negedge clk);
    chk("seq strobe mid-cycle", 32'(bus.active), 32'b010);
    @(posedge clk);
    #1;
    chk("seq back-to-back", 32'(bus.active), 32'b010);
    chk("seq masked busy", 32'(bus.port_EF_masked), 32'b1);
    rst = 1'b1;
    #1;
    chk("seq comb during reset", 32'(bus.addr_is_IO), 32'b1);
    @(posedge clk);
    #1;
    chk("seq reset clears active", 32'(bus.active), 32'b000);
    chk("seq reset clears io_reg", 32'(bus.addr_is_IO_reg), 32'b0);
    chk("seq reset masked ready", 32'(bus.port_EF_masked), 32'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("seq post-reset strobe", 32'(bus.active), 32'b010);
    chk("seq post-reset io_reg", 32'(bus.addr_is_IO_reg), 32'b1);
    bus.active_enable = 1'b0;
    @(posedge clk);
    #1;
    chk("seq strobe drops", 32'(bus.active), 32'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
